sa_cache_core: RTL and testbench

//  Parametrised N-way set-associative cache core: tag/valid/dirty/LRU state plus line data storage.

---
 rtl/sa_cache_core.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_sa_cache_core.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_cache_core.sv
// sa_cache_core
//   N-way set-associative write-back / write-allocate cache core. Holds the
//   valid/dirty/tag/LRU state and the line data. A single request is in
//   flight at a time: it is looked up, a victim is chosen on a miss, the
//   victim is written back word-serially if dirty, the line is refilled
//   word-serially, and the access is completed in the RESP state.
//
//   Optional feature: define CACHE_STATS_EN to add the hit/miss counters
//   and their stats_clr / hit_count / miss_count ports.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_*                 CPU request (valid/ready, we, tag, index, word, wdata)
//   resp_*                one-cycle response pulse (valid, rdata, hit)
//   mem_req_*             line request to memory (valid/ready, we, tag, index)
//   mem_wdata_*           write-back beats, word 0 first (valid/ready, data)
//   mem_rdata_*           fill beats, word 0 first (valid, data)
//   stats_clr, hit_count, miss_count   only with CACHE_STATS_EN
module sa_cache_core #(
  parameter int WAYS            = 4,
  parameter int SETS            = 64,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int TAG_BITS        = 18,
  parameter int DATA_WIDTH      = 32,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WORDS  = LINE_SIZE_BYTES * 8 / DATA_WIDTH,
  localparam int WORD_W = $clog2(WORDS),
  localparam int AGE_W  = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [IDX_W-1:0]      req_index,
  input  logic [WORD_W-1:0]     req_word,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [TAG_BITS-1:0]   mem_req_tag,
  output logic [IDX_W-1:0]      mem_req_index,
  output logic                  mem_wdata_valid,
  input  logic                  mem_wdata_ready,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rdata_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_DATA, S_FILL_REQ, S_FILL_DATA, S_RESP
  } state_t;

  state_t state_reg, state_next;

  // Latched request and per-request bookkeeping
  logic [TAG_BITS-1:0]   tag_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [WORD_W-1:0]     word_reg;
  logic                  we_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [AGE_W-1:0]      way_reg;         // hit way, or victim way on a miss
  logic                  hit_reg;
  logic [TAG_BITS-1:0]   victim_tag_reg;
  logic [WORD_W-1:0]     cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] fill_word_reg;   // requested word captured during fill

  // Line state
  logic [SETS-1:0]     valid_reg [WAYS];
  logic [SETS-1:0]     dirty_reg [WAYS];
  logic [AGE_W-1:0]    age_reg   [SETS][WAYS];
  logic [TAG_BITS-1:0] tag_mem   [WAYS][SETS];

  // Lookup results
  logic [WAYS-1:0]  hit_vec;
  logic             hit_any, inv_any, victim_dirty;
  logic [AGE_W-1:0] hit_way, inv_way, lru_way, victim_way;

  // Data RAM ports
  logic [DATA_WIDTH-1:0]   way_rdata [WAYS];
  logic [WORD_W-1:0]       rd_word;
  logic [IDX_W+WORD_W-1:0] rd_addr, wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    fill_wr, resp_wr;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_hit
    assign hit_vec[gi] = valid_reg[gi][idx_reg] && (tag_mem[gi][idx_reg] == tag_reg);
  end

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    lru_way = '0;
    // Descending scan so the lowest matching index wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit_any = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!valid_reg[w][idx_reg]) begin
        inv_any = 1'b1;
        inv_way = AGE_W'(w);
      end
      if (age_reg[idx_reg][w] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
    end
    victim_way   = inv_any ? inv_way : lru_way;
    victim_dirty = valid_reg[victim_way][idx_reg] && dirty_reg[victim_way][idx_reg];
  end

  // Data RAM: one array per way, registered read. The read address follows
  // the requested word during LOOKUP (hit data lands for RESP) and runs one
  // beat ahead of the write-back counter so mem_wdata is ready each beat.
  assign rd_word = (state_reg == S_WB_REQ || state_reg == S_WB_DATA) ? cnt_next : word_reg;
  assign rd_addr = {idx_reg, rd_word};
  assign fill_wr = (state_reg == S_FILL_DATA) && mem_rdata_valid;
  assign resp_wr = (state_reg == S_RESP) && we_reg;
  assign wr_addr = {idx_reg, fill_wr ? cnt_reg : word_reg};
  assign wr_data = fill_wr ? mem_rdata : wdata_reg;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [DATA_WIDTH-1:0] data_mem [SETS*WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if ((fill_wr || resp_wr) && (way_reg == AGE_W'(gi))) data_mem[wr_addr] <= wr_data;
      rdata_q <= data_mem[rd_addr];
    end
    assign way_rdata[gi] = rdata_q;
  end

  // Tag storage is not reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (fill_wr && cnt_reg == WORD_W'(WORDS - 1)) tag_mem[way_reg][idx_reg] <= tag_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_hit        = 1'b0;
    resp_rdata      = '0;
    mem_req_valid   = 1'b0;
    mem_req_we      = 1'b0;
    mem_req_tag     = '0;
    mem_req_index   = '0;
    mem_wdata_valid = 1'b0;
    mem_wdata       = '0;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit_any)           state_next = S_RESP;
        else if (victim_dirty) state_next = S_WB_REQ;
        else                   state_next = S_FILL_REQ;
      end
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_tag   = victim_tag_reg;
        mem_req_index = idx_reg;
        if (mem_req_ready) state_next = S_WB_DATA;
      end
      S_WB_DATA: begin
        mem_wdata_valid = 1'b1;
        mem_wdata       = way_rdata[way_reg];
        if (mem_wdata_ready) begin
          if (cnt_reg == WORD_W'(WORDS - 1)) begin
            cnt_next   = '0;
            state_next = S_FILL_REQ;
          end else begin
            cnt_next = cnt_reg + WORD_W'(1);
          end
        end
      end
      S_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_tag   = tag_reg;
        mem_req_index = idx_reg;
        if (mem_req_ready) state_next = S_FILL_DATA;
      end
      S_FILL_DATA: begin
        if (mem_rdata_valid) begin
          if (cnt_reg == WORD_W'(WORDS - 1)) begin
            cnt_next   = '0;
            state_next = S_RESP;
          end else begin
            cnt_next = cnt_reg + WORD_W'(1);
          end
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_hit   = hit_reg;
        if (we_reg)       resp_rdata = wdata_reg;
        else if (hit_reg) resp_rdata = way_rdata[way_reg];
        else              resp_rdata = fill_word_reg;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      tag_reg        <= '0;
      idx_reg        <= '0;
      word_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      way_reg        <= '0;
      hit_reg        <= 1'b0;
      victim_tag_reg <= '0;
      fill_word_reg  <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_reg[w] <= '0;
        dirty_reg[w] <= '0;
        for (int s = 0; s < SETS; s++) age_reg[s][w] <= AGE_W'(w);
      end
    end else begin
      cnt_reg <= cnt_next;
      if (state_reg == S_IDLE && req_valid) begin
        tag_reg   <= req_tag;
        idx_reg   <= req_index;
        word_reg  <= req_word;
        we_reg    <= req_we;
        wdata_reg <= req_wdata;
      end
      if (state_reg == S_LOOKUP) begin
        hit_reg        <= hit_any;
        way_reg        <= hit_any ? hit_way : victim_way;
        victim_tag_reg <= tag_mem[victim_way][idx_reg];
        // The victim is invalid from here until its refill completes, so an
        // interrupted refill can never leave a half-written line valid.
        if (!hit_any) valid_reg[victim_way][idx_reg] <= 1'b0;
      end
      if (fill_wr) begin
        if (cnt_reg == word_reg) fill_word_reg <= mem_rdata;
        if (cnt_reg == WORD_W'(WORDS - 1)) begin
          valid_reg[way_reg][idx_reg] <= 1'b1;
          dirty_reg[way_reg][idx_reg] <= 1'b0;
        end
      end
      if (state_reg == S_RESP) begin
        if (we_reg) dirty_reg[way_reg][idx_reg] <= 1'b1;
        // Ages younger than the accessed way grow by one; accessed way becomes 0.
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == way_reg)
            age_reg[idx_reg][w] <= '0;
          else if (age_reg[idx_reg][w] < age_reg[idx_reg][way_reg])
            age_reg[idx_reg][w] <= age_reg[idx_reg][w] + AGE_W'(1);
        end
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (stats_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_reg == S_RESP) begin
      if (hit_reg) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sa_cache_core.sv
// Testbench for sa_cache_core: drives CPU requests, acts as the memory side,
// and checks every response and memory transfer against a behavioural cache
// model (recency list per set, backing memory as an associative array).
module tb_sa_cache_core;
  localparam int WAYS = 4, SETS = 64, TAG_BITS = 18, DATA_WIDTH = 32;
  localparam int WORDS = 16, IDX_W = 6, WORD_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready, req_we;
  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_W-1:0] req_index;
  logic [WORD_W-1:0] req_word;
  logic [31:0] req_wdata;
  logic resp_valid, resp_hit;
  logic [31:0] resp_rdata;
  logic mem_req_valid, mem_req_ready, mem_req_we;
  logic [TAG_BITS-1:0] mem_req_tag;
  logic [IDX_W-1:0] mem_req_index;
  logic mem_wdata_valid, mem_wdata_ready;
  logic [31:0] mem_wdata;
  logic mem_rdata_valid;
  logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic stats_clr;
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sa_cache_core dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_tag(req_tag), .req_index(req_index), .req_word(req_word), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_tag(mem_req_tag), .mem_req_index(mem_req_index),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .stats_clr(stats_clr), .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // ---------------- behavioural model ----------------
  bit          m_valid [WAYS][SETS];
  bit          m_dirty [WAYS][SETS];
  logic [17:0] m_tag   [WAYS][SETS];
  logic [31:0] m_data  [WAYS][SETS][WORDS];
  int          m_rec   [SETS][WAYS];   // way numbers, most recently used first
  logic [31:0] backing [logic [31:0]];
  int          mdl_hits = 0, mdl_misses = 0;

  function automatic logic [31:0] mem_key(logic [17:0] t, logic [5:0] s, int w);
    return {4'b0, t, s, 4'(w)};
  endfunction

  function automatic logic [31:0] mem_word(logic [17:0] t, logic [5:0] s, int w);
    logic [31:0] k;
    k = mem_key(t, s, w);
    if (backing.exists(k)) return backing[k];
    return (k * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
        m_rec[s][w]   = w;
      end
    mdl_hits = 0;
    mdl_misses = 0;
  endfunction

  function automatic void touch(int s, int w);
    int pos = 0;
    for (int i = 0; i < WAYS; i++) if (m_rec[s][i] == w) pos = i;
    for (int i = pos; i > 0; i--) m_rec[s][i] = m_rec[s][i-1];
    m_rec[s][0] = w;
  endfunction

  // One complete CPU access, acting as memory and checking everything seen.
  // Starts and ends at a falling edge with the DUT expected idle.
  task automatic do_access(input bit we, input logic [17:0] tag, input logic [5:0] idx,
                           input logic [3:0] word, input logic [31:0] wdata,
                           input int stall, input string name);
    bit exp_hit = 1'b0, exp_wb, done = 1'b0, req_open = 1'b0, fill_active = 1'b0;
    int way = -1, n_req = 0, wb_beats = 0, fill_beats = 0, stall_left, resp_cyc = 0;
    logic [17:0] wb_tag, exp_t;
    logic [31:0] wb_line [WORDS];
    logic [31:0] exp_fill [WORDS];
    logic [31:0] exp_rdata;
    logic snap_we;
    logic [17:0] snap_tag;
    logic [5:0] snap_idx;
    bit exp_we;

    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][idx] && m_tag[w][idx] == tag) begin exp_hit = 1'b1; way = w; end
    if (!exp_hit) begin
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[w][idx]) way = w;
      if (way < 0) way = m_rec[idx][WAYS-1];
    end
    exp_wb = !exp_hit && m_valid[way][idx] && m_dirty[way][idx];
    wb_tag = m_tag[way][idx];
    for (int i = 0; i < WORDS; i++) begin
      wb_line[i]  = m_data[way][idx][i];
      exp_fill[i] = mem_word(tag, idx, i);
    end
    if (we)           exp_rdata = wdata;
    else if (exp_hit) exp_rdata = m_data[way][idx][word];
    else              exp_rdata = exp_fill[word];
    stall_left = stall;

    for (int i = 0; i < 50 && req_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL %s req_ready got %b want 1", name, req_ready);
    if (req_ready !== 1'b1) errors++;
    req_valid = 1'b1; req_we = we; req_tag = tag; req_index = idx; req_word = word; req_wdata = wdata;

    for (int cyc = 1; cyc <= 600 && !done; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_req_ready = 1'b0; mem_wdata_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = $urandom;
      if (resp_valid === 1'b1) begin
        done = 1'b1;
        resp_cyc = cyc;
        checks++;
        if (resp_hit !== exp_hit) begin errors++; $display("FAIL %s resp_hit got %b want %b", name, resp_hit, exp_hit); end
        checks++;
        if (resp_rdata !== exp_rdata) begin errors++; $display("FAIL %s resp_rdata got %h want %h", name, resp_rdata, exp_rdata); end
      end else begin
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL %s req_ready busy got %b want 0", name, req_ready); end
        // Fill beats, or ignored noise on the fill bus before the fill starts.
        if (fill_active && fill_beats < WORDS) begin
          if ($urandom_range(0, 3) != 0) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = exp_fill[fill_beats];
            fill_beats++;
          end
        end else if (!fill_active) begin
          mem_rdata_valid = 1'($urandom_range(0, 1));
        end
        if (mem_req_valid === 1'b1) begin
          if (!req_open) begin
            req_open = 1'b1;
            n_req++;
            exp_we = exp_wb && n_req == 1;
            exp_t  = exp_we ? wb_tag : tag;
            checks++;
            if (mem_req_we !== exp_we || mem_req_tag !== exp_t || mem_req_index !== idx) begin
              errors++;
              $display("FAIL %s mem_req got we=%b tag=%h idx=%0d want we=%b tag=%h idx=%0d",
                       name, mem_req_we, mem_req_tag, mem_req_index, exp_we, exp_t, idx);
            end
            snap_we = mem_req_we; snap_tag = mem_req_tag; snap_idx = mem_req_index;
          end else begin
            checks++;
            if (mem_req_we !== snap_we || mem_req_tag !== snap_tag || mem_req_index !== snap_idx) begin
              errors++;
              $display("FAIL %s mem_req unstable got we=%b tag=%h idx=%0d want we=%b tag=%h idx=%0d",
                       name, mem_req_we, mem_req_tag, mem_req_index, snap_we, snap_tag, snap_idx);
            end
          end
          if (stall_left > 0) stall_left--;
          else begin
            mem_req_ready = 1'b1;
            req_open = 1'b0;
            if (mem_req_we === 1'b0) fill_active = 1'b1;
          end
        end
        if (mem_wdata_valid === 1'b1 && $urandom_range(0, 3) != 0) begin
          mem_wdata_ready = 1'b1;
          checks++;
          if (wb_beats >= WORDS) begin
            errors++; $display("FAIL %s extra wb beat got %0d want %0d", name, wb_beats + 1, WORDS);
          end else if (mem_wdata !== wb_line[wb_beats]) begin
            errors++; $display("FAIL %s wb beat %0d got %h want %h", name, wb_beats, mem_wdata, wb_line[wb_beats]);
          end
          wb_beats++;
        end
      end
    end
    mem_req_ready = 1'b0; mem_wdata_ready = 1'b0; mem_rdata_valid = 1'b0;

    checks++;
    if (!done) begin errors++; $display("FAIL %s timeout got no resp want resp_valid", name); end
    else if (exp_hit && resp_cyc != 2) begin errors++; $display("FAIL %s hit latency got %0d want 2", name, resp_cyc); end
    checks++;
    if (n_req != (exp_hit ? 0 : (exp_wb ? 2 : 1))) begin
      errors++; $display("FAIL %s mem_req count got %0d want %0d", name, n_req, exp_hit ? 0 : (exp_wb ? 2 : 1));
    end
    checks++;
    if (wb_beats != (exp_wb ? WORDS : 0)) begin
      errors++; $display("FAIL %s wb beats got %0d want %0d", name, wb_beats, exp_wb ? WORDS : 0);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL %s resp pulse got %b want 0", name, resp_valid); end

    // Advance the model.
    if (exp_wb) for (int i = 0; i < WORDS; i++) backing[mem_key(wb_tag, idx, i)] = wb_line[i];
    if (!exp_hit) begin
      for (int i = 0; i < WORDS; i++) m_data[way][idx][i] = exp_fill[i];
      m_tag[way][idx] = tag; m_valid[way][idx] = 1'b1; m_dirty[way][idx] = 1'b0;
    end
    if (we) begin m_data[way][idx][word] = wdata; m_dirty[way][idx] = 1'b1; end
    touch(idx, way);
    if (exp_hit) mdl_hits++; else mdl_misses++;
    $display("txn %s we=%0b tag=%h idx=%0d word=%0d rdata=%h hit=%0b wb=%0b", name, we, tag, idx, word, resp_rdata, exp_hit, exp_wb);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_rdata !== 32'h0 ||
        mem_req_valid !== 1'b0 || mem_req_we !== 1'b0 || mem_req_tag !== 18'h0 || mem_req_index !== 6'h0 ||
        mem_wdata_valid !== 1'b0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL %s outputs got rdy=%b rv=%b hit=%b rd=%h mv=%b mwe=%b mt=%h mi=%0d wv=%b wd=%h want idle zeros",
               name, req_ready, resp_valid, resp_hit, resp_rdata, mem_req_valid, mem_req_we,
               mem_req_tag, mem_req_index, mem_wdata_valid, mem_wdata);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++; $display("FAIL %s counters got %0d/%0d want 0/0", name, hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_release");
  endtask

  task automatic test_miss_fill();
    for (int i = 0; i < WORDS; i++) backing[mem_key(18'h1, 6'd3, i)] = 32'hA0 + i;
    do_access(1'b0, 18'h1, 6'd3, 4'd0, 32'h0, 0, "miss_fill");
  endtask

  task automatic test_hit_latency();
    do_access(1'b0, 18'h1, 6'd3, 4'd5, 32'h0, 0, "hit_word5");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_access(i[0], 18'h1, 6'd3, 4'(i * 3), $urandom, 0, "b2b_hit");
  endtask

  task automatic test_lru_evict();
    for (int t = 1; t <= 4; t++) do_access(1'b0, 18'(t), 6'd7, 4'(t), 32'h0, 0, "lru_fill");
    do_access(1'b0, 18'h1, 6'd7, 4'd0, 32'h0, 0, "lru_touch1");
    do_access(1'b0, 18'h5, 6'd7, 4'd0, 32'h0, 0, "lru_evict2");
    do_access(1'b0, 18'h1, 6'd7, 4'd1, 32'h0, 0, "lru_keep1");
    do_access(1'b0, 18'h3, 6'd7, 4'd1, 32'h0, 0, "lru_keep3");
    do_access(1'b0, 18'h4, 6'd7, 4'd1, 32'h0, 0, "lru_keep4");
    do_access(1'b0, 18'h2, 6'd7, 4'd1, 32'h0, 0, "lru_gone2");
  endtask

  task automatic test_writeback();
    do_access(1'b1, 18'h1, 6'd7, 4'd2, 32'hDEADBEEF, 0, "wr_hit");
    for (int t = 9; t <= 12; t++) do_access(1'b0, 18'(t), 6'd7, 4'd0, 32'h0, 0, "wb_force");
    do_access(1'b0, 18'h1, 6'd7, 4'd2, 32'h0, 0, "wb_reload");
  endtask

  task automatic test_req_stall();
    do_access(1'b0, 18'h2A, 6'd20, 4'd3, 32'h0, 10, "stall_fill");
    do_access(1'b1, 18'h2B, 6'd20, 4'd4, 32'h1234_5678, 10, "stall_wmiss");
  endtask

  task automatic test_reset_mid_fill();
    bit seen = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_tag = 18'h3F; req_index = 6'd40; req_word = 4'd1; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_req_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_fill mem_req_valid got 0 want 1"); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata = mem_word(18'h3F, 6'd40, b);
      @(negedge clk);
    end
    mem_rdata_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_fill_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    do_access(1'b0, 18'h3F, 6'd40, 4'd1, 32'h0, 0, "mid_fill_reread");
  endtask

  task automatic test_random();
    for (int n = 0; n < 120; n++)
      do_access(1'($urandom_range(0, 1)), 18'($urandom_range(1, 6)), 6'($urandom_range(16, 19)),
                4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 2), "random");
  endtask

  task automatic test_stats();
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_count !== 32'(mdl_hits) || miss_count !== 32'(mdl_misses)) begin
      errors++; $display("FAIL stats got %0d/%0d want %0d/%0d", hit_count, miss_count, mdl_hits, mdl_misses);
    end
    stats_clr = 1'b1;
    do_access(1'b0, 18'h3F, 6'd40, 4'd2, 32'h0, 0, "stats_clr_hit");
    stats_clr = 1'b0;
    checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++; $display("FAIL stats_clr got %0d/%0d want 0/0", hit_count, miss_count);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_tag = '0; req_index = '0; req_word = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_wdata_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
`ifdef CACHE_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    test_reset();
    test_miss_fill();
    test_hit_latency();
    test_back_to_back();
    test_lru_evict();
    test_writeback();
    test_req_stall();
    test_reset_mid_fill();
    test_random();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
